// File: rtl/led_pattern_gen.sv
// LED pattern sequencer: tick divider steps rotate-left/right, ping-pong or fill patterns.
// Define LED_ACTIVE_LOW_EN to drive the inverted pattern onto the LED pins.
module led_pattern_gen #(
  parameter int LED_W    = 4,
  parameter int TICK_CNT = 10_000_000,
  parameter int CNT_W    = $clog2(TICK_CNT)
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [1:0]       mode_sel,
  input  logic             mode_load,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step_tick,
  output logic [1:0]       mode_cur
);

  localparam logic [1:0] MODE_ROTL = 2'b00;
  localparam logic [1:0] MODE_ROTR = 2'b01;
  localparam logic [1:0] MODE_PING = 2'b10;

  localparam logic [LED_W-1:0] LSB_ONLY = {{(LED_W-1){1'b0}}, 1'b1};
  localparam logic [LED_W-1:0] MSB_ONLY = {1'b1, {(LED_W-1){1'b0}}};
  localparam logic [LED_W-1:0] ALL_ONES = {LED_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W:0]   PER_ONE  = (CNT_W+1)'(1);
  localparam logic [CNT_W:0]   PER_BASE = (CNT_W+1)'(TICK_CNT);

  logic [CNT_W-1:0] r_cnt;
  logic [LED_W-1:0] r_led;
  logic             r_dir_up;
  logic             r_tick;
  logic [1:0]       r_mode;

  logic [CNT_W-1:0] w_cnt_nxt;
  logic [LED_W-1:0] w_led_nxt;
  logic             w_dir_nxt;
  logic             w_tick_nxt;
  logic [1:0]       w_mode_nxt;

  logic [CNT_W:0]   w_period;
  logic             w_terminal;
  logic [LED_W-1:0] w_led_dec;
  logic [LED_W-1:0] w_led_inc;
  logic             w_onehot;
  logic             w_therm;
  logic             w_go_up;

  // >= rather than == so a faster speed setting steps immediately instead of waiting for a wrap
  assign w_period   = PER_BASE >> speed;
  assign w_terminal = ({1'b0, r_cnt} >= (w_period - PER_ONE));

  assign w_led_dec = r_led - LSB_ONLY;
  assign w_led_inc = r_led + LSB_ONLY;
  assign w_onehot  = (r_led != '0) && ((r_led & w_led_dec) == '0);
  assign w_therm   = (r_led != '0) && ((r_led & w_led_inc) == '0);
  assign w_go_up   = (r_dir_up && !r_led[LED_W-1]) || r_led[0];

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_cnt    <= '0;
      r_led    <= LSB_ONLY;
      r_dir_up <= 1'b1;
      r_tick   <= 1'b0;
      r_mode   <= MODE_ROTL;
    end else begin
      r_cnt    <= w_cnt_nxt;
      r_led    <= w_led_nxt;
      r_dir_up <= w_dir_nxt;
      r_tick   <= w_tick_nxt;
      r_mode   <= w_mode_nxt;
    end
  end

  always_comb begin
    w_cnt_nxt  = r_cnt;
    w_led_nxt  = r_led;
    w_dir_nxt  = r_dir_up;
    w_tick_nxt = 1'b0;
    w_mode_nxt = r_mode;
    if (mode_load) begin
      w_mode_nxt = mode_sel;
      w_cnt_nxt  = '0;
      w_dir_nxt  = 1'b1;
      w_led_nxt  = (mode_sel == MODE_ROTR) ? MSB_ONLY : LSB_ONLY;
    end else if (!pause) begin
      if (w_terminal) begin
        w_cnt_nxt  = '0;
        w_tick_nxt = 1'b1;
        case (r_mode)
          MODE_ROTL: w_led_nxt = (!w_onehot || r_led[LED_W-1]) ? LSB_ONLY : (r_led << 1);
          MODE_ROTR: w_led_nxt = (!w_onehot || r_led[0]) ? MSB_ONLY : (r_led >> 1);
          MODE_PING: begin
            // direction flips on the step that lands on an end, so ends are shown once
            if (!w_onehot) begin
              w_led_nxt = LSB_ONLY;
              w_dir_nxt = 1'b1;
            end else if (w_go_up) begin
              w_led_nxt = r_led << 1;
              w_dir_nxt = !r_led[LED_W-2];
            end else begin
              w_led_nxt = r_led >> 1;
              w_dir_nxt = r_led[1];
            end
          end
          default:   w_led_nxt = (!w_therm || (r_led == ALL_ONES)) ? LSB_ONLY
                                                                   : {r_led[LED_W-2:0], 1'b1};
        endcase
      end else begin
        w_cnt_nxt = r_cnt + CNT_ONE;
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign led = ~r_led;
`else
  assign led = r_led;
`endif
  assign step_tick = r_tick;
  assign mode_cur  = r_mode;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Scoreboard bench for led_pattern_gen: directed test-plan scenarios followed by random traffic.
module tb_led_pattern_gen;
  localparam int LW = 4;
  localparam int TK = 8;

  logic          sys_clk   = 1'b0;
  logic          sys_rst_n = 1'b0;
  logic [1:0]    mode_sel  = 2'b00;
  logic          mode_load = 1'b0;
  logic [1:0]    speed     = 2'b00;
  logic          pause     = 1'b0;
  logic [LW-1:0] led;
  logic          step_tick;
  logic [1:0]    mode_cur;

  always #5 sys_clk = ~sys_clk;

  led_pattern_gen #(.LED_W(LW), .TICK_CNT(TK)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .mode_sel  (mode_sel),
    .mode_load (mode_load),
    .speed     (speed),
    .pause     (pause),
    .led       (led),
    .step_tick (step_tick),
    .mode_cur  (mode_cur)
  );

  typedef struct packed {
    logic [LW-1:0] led;
    logic          tick;
    logic [1:0]    mode;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_exp;
  obs_t mon_act;
  int   n_chk  = 0;
  int   n_fail = 0;

  // reference model: a step index into each mode's sequence plus a cycle counter
  logic [1:0] m_mode = 2'b00;
  int         m_k    = 0;
  int         m_cnt  = 0;
  logic       m_tick = 1'b0;

  function automatic logic [LW-1:0] pat(input logic [1:0] mode, input int k);
    int p;
    int pos;
    case (mode)
      2'b00: pos = k % LW;
      2'b01: pos = LW - 1 - (k % LW);
      2'b10: begin
        p   = k % (2*LW - 2);
        pos = (p < LW) ? p : (2*LW - 2 - p);
      end
      default: return LW'((1 << ((k % LW) + 1)) - 1);
    endcase
    return LW'(1 << pos);
  endfunction

  task automatic cyc(input bit rst, input bit ld, input logic [1:0] sel,
                     input logic [1:0] spd, input bit pse);
    obs_t e;
    int   per;
    sys_rst_n = !rst;
    mode_load = ld;
    mode_sel  = sel;
    speed     = spd;
    pause     = pse;
    if (rst) begin
      m_mode = 2'b00; m_k = 0; m_cnt = 0; m_tick = 1'b0;
    end else if (ld) begin
      m_mode = sel; m_k = 0; m_cnt = 0; m_tick = 1'b0;
    end else if (pse) begin
      m_tick = 1'b0;
    end else begin
      per = TK >> spd;
      if (m_cnt >= per - 1) begin
        m_cnt = 0; m_k = m_k + 1; m_tick = 1'b1;
      end else begin
        m_cnt = m_cnt + 1; m_tick = 1'b0;
      end
    end
    e.led = pat(m_mode, m_k);
`ifdef LED_ACTIVE_LOW_EN
    e.led = ~e.led;
`endif
    e.tick = m_tick;
    e.mode = m_mode;
    exp_q.push_back(e);
    @(negedge sys_clk);
    #1;
  endtask

  always @(negedge sys_clk) begin
    if (exp_q.size() > 0) begin
      mon_exp      = exp_q.pop_front();
      mon_act.led  = led;
      mon_act.tick = step_tick;
      mon_act.mode = mode_cur;
      n_chk++;
      if (mon_act !== mon_exp) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got led=%b tick=%b mode=%b, expected led=%b tick=%b mode=%b",
                 $time, mon_act.led, mon_act.tick, mon_act.mode,
                 mon_exp.led, mon_exp.tick, mon_exp.mode);
      end
    end
  end

  logic [1:0] r_sel;
  logic [1:0] r_spd;
  bit         r_pse;
  bit         r_ld;
  bit         r_rst;

  initial begin
    @(negedge sys_clk);
    #1;
    repeat (3) cyc(1, 0, 2'd0, 2'd0, 0);
    // rotate-left at slowest speed
    repeat (40) cyc(0, 0, 2'd0, 2'd0, 0);
    // ping-pong, period 4
    cyc(0, 1, 2'd2, 2'd1, 0);
    repeat (30) cyc(0, 0, 2'd2, 2'd1, 0);
    // fill, period 1
    cyc(0, 1, 2'd3, 2'd3, 0);
    repeat (10) cyc(0, 0, 2'd3, 2'd3, 0);
    // pause mid-period, load rotate-right while paused, then release
    cyc(0, 1, 2'd0, 2'd0, 0);
    repeat (3)  cyc(0, 0, 2'd0, 2'd0, 0);
    repeat (20) cyc(0, 0, 2'd0, 2'd0, 1);
    cyc(0, 1, 2'd1, 2'd0, 1);
    repeat (3)  cyc(0, 0, 2'd1, 2'd0, 1);
    repeat (12) cyc(0, 0, 2'd1, 2'd0, 0);
    // load coincident with a terminal count created by a speed-up at cnt=5
    cyc(0, 1, 2'd0, 2'd0, 0);
    repeat (5) cyc(0, 0, 2'd0, 2'd0, 0);
    cyc(0, 1, 2'd0, 2'd2, 0);
    repeat (8) cyc(0, 0, 2'd0, 2'd2, 0);
    // slow-down mid-period, then reset mid-operation
    repeat (3)  cyc(0, 0, 2'd0, 2'd0, 0);
    repeat (2)  cyc(1, 0, 2'd0, 2'd0, 0);
    repeat (12) cyc(0, 0, 2'd0, 2'd0, 0);

    r_sel = 2'd0; r_spd = 2'd0; r_pse = 0;
    for (int i = 0; i < 1500; i++) begin
      r_ld  = ($urandom_range(0, 19) == 0);
      r_rst = ($urandom_range(0, 399) == 0);
      r_sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) r_spd = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) r_pse = !r_pse;
      cyc(r_rst, r_ld, r_sel, r_spd, r_pse);
    end

    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/led_pattern_gen.md
# led_pattern_gen

Parametrised LED pattern sequencer for the board LED bank. A free-running tick divider advances a registered LED pattern once per period. The block supports configurable LED count, four selectable patterns, run-time speed selection and pause. It sits between the board clock/reset and the LED pins, and replaces the fixed 4-LED rotate-left flow light.

## Interface
- `LED_W`, default 4: number of LEDs; legal range 2..16.
- `TICK_CNT`, default 10_000_000: base step period in `sys_clk` cycles; minimum 8.
- `CNT_W`, default `$clog2(TICK_CNT)`: divider width (derived; not overridden).
- `sys_clk` in 1: system clock; all logic on its rising edge.
- `sys_rst_n` in 1: asynchronous, active-low reset.
- `mode_sel` in 2: pattern to load; 00 rotate-left, 01 rotate-right, 10 ping-pong, 11 fill.
- `mode_load` in 1: single-cycle pulse; latches `mode_sel` and restarts the pattern.
- `speed` in 2: step period = `TICK_CNT >> speed`; 0 is slowest, 3 is 8x faster.
- `pause` in 1: level; while high, the divider and pattern freeze.
- `led` out `LED_W`: registered LED drive.
- `step_tick` out 1: registered one-cycle pulse, high in the cycle in which `led` shows a newly stepped value.
- `mode_cur` out 2: currently active mode.

## Operation
- Reset values:
  - `cnt` = 0, `mode_cur` = 00, direction = up, `step_tick` = 0.
  - `led` = 1 (LSB only).
- Divider:
  - `period` = `TICK_CNT >> speed`, evaluated every cycle.
  - When `cnt >= period-1`, `cnt` returns to 0 and a step occurs; otherwise `cnt` increments.
  - The `>=` comparison lets a speed increase mid-period step on the next cycle instead of waiting for a counter wrap.
- Step behaviour per mode. In each rule the first pattern is the start pattern.
  - Rotate-left: LSB-only start; shift left; MSB-only wraps to LSB-only.
  - Rotate-right: MSB-only start; shift right; LSB-only wraps to MSB-only.
  - Ping-pong: LSB-only start, direction up. Shift toward the MSB while up; on reaching MSB-only, the direction flips to down. Shift toward the LSB while down; on reaching LSB-only, the direction flips to up. The end positions are not repeated, so `LED_W`=4 gives 0001,0010,0100,1000,0100,0010,0001,0010…
  - Fill: LSB-only start; `led <= {led[LED_W-2:0],1'b1}`; all-ones wraps to LSB-only.
- `mode_load`:
  - On the next edge, `mode_cur` takes `mode_sel`, `led` takes the start pattern of the new mode, `cnt` goes to 0, direction goes to up, and `step_tick` stays 0.
  - `mode_load` is honoured while paused; the loaded pattern is then held.
- Priority, highest first: reset, `mode_load`, `pause`, step.
  - `mode_load` coincident with a terminal count: the load wins and no step occurs.
  - `pause` coincident with a terminal count: no step; `cnt` holds at its value; the step fires on the first unpaused cycle.
- Illegal pattern recovery: if `led` ever holds a state that is illegal for the mode (all-zero, or multi-hot in a one-hot mode), the next step loads the start pattern.

## Timing
- Step latency: `led` and `step_tick` update on the same edge at which `cnt` reaches `period-1`. Step spacing is exactly `period` cycles in steady state.
- `step_tick` is high for exactly one cycle per step and is never high on a load or reset cycle.
- Mode-load latency: 1 cycle from the `mode_load` sample edge to the new `led` value. The first step follows `period` cycles later.
- Speed change from a slower to a faster setting with `cnt >= new period-1`: the step occurs on the next edge. Change to a slower setting: the current period simply extends.
- Reset mid-operation: all outputs return to their reset values asynchronously and ignore in-flight state; the first step comes `TICK_CNT` cycles after deassertion.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- `LED_ACTIVE_LOW_EN`:
  - Defined: the `led` port drives the bitwise inverse of the internal pattern, so the reset value on the pins is all-ones except bit 0 = 0. This serves boards whose LEDs are wired to VCC.
  - Undefined: `led` equals the internal pattern (active-high).
  - `step_tick` and `mode_cur` are unaffected in both cases.

## Test plan
All tests use `LED_W`=4, `TICK_CNT`=8, active-high unless noted.
- Reset, then run with mode 00, `speed`=0. Required: `led` = 0001 until the first step at cycle 8, then 0010, 0100, 1000, 0001. `step_tick` pulses every 8 cycles.
- Pulse `mode_load` with `mode_sel`=10, `speed`=1. Required: `led` shows the sequence 0001,0010,0100,1000,0100,0010,0001, with steps 4 cycles apart and no repeat at either end.
- Mode 11, `speed`=3 (period 1). Required: `led` steps every cycle through 0001,0011,0111,1111,0001, and `step_tick` stays high continuously.
- Mode 00: hold `pause` for 20 cycles mid-period, then raise `mode_load` (mode 01) while paused, then release. Required: `led` is frozen during the pause, becomes 1000 one cycle after the load, and the next step comes 8 cycles after release, giving 0100.
- Assert `mode_load` on the terminal-count cycle with `speed` changed from 0 to 2 at `cnt`=5. Required: the load wins with no `step_tick`; after the load, steps occur every 2 cycles.
- Build with `LED_ACTIVE_LOW_EN` and reset. Required: `led` = 1110, and after the first step `led` = 1101; `mode_cur` = 00 throughout.
